// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the iterative multiplier.
package fp_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned EXP_FW  = 8;
    localparam int unsigned SIG_W   = MANT_W + 1;
    localparam int unsigned PROD_W  = 2 * SIG_W;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned EXP_W   = 10;

    typedef struct packed {
        logic              sign;
        logic [EXP_FW-1:0] exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2
    } state_t;

    // Assemble a packed fp32 value from its fields.
    function automatic fp32_t fp_pack(input logic s, input logic [EXP_FW-1:0] e,
                                      input logic [MANT_W-1:0] m);
        fp32_t f;
        f.sign = s;
        f.exp  = e;
        f.mant = m;
        return f;
    endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational normalise / round / flag / pack stage for the 48-bit product.
// Optional round-to-nearest-even enabled by defining FP_MUL_ROUND_EN;
// default build truncates.
module fp_normalize
    import fp_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_FW-1:0] exp_a,
    input  logic [EXP_FW-1:0] exp_b,
    input  logic [PROD_W-1:0] prod,
    output fp32_t             result_c,
    output logic              overflow_c,
    output logic              underflow_c
);

    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);

    logic                     carry;
    logic                     rcarry;
    logic [MANT_W-1:0]        frac;
    logic signed [EXP_W-1:0]  exp_s;
    logic                     zero_op;
`ifdef FP_MUL_ROUND_EN
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic [MANT_W+1:0]        sig_r;
`else
    logic                     unused_low_bits;
    assign unused_low_bits = ^prod[MANT_W-1:0];
`endif

    // Pick the significand window, optionally round, then classify the exponent.
    always_comb begin
        rcarry      = 1'b0;
        result_c    = fp_pack(sign, '0, '0);
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        zero_op     = (exp_a == '0) || (exp_b == '0);
        carry       = prod[PROD_W-1];
        frac        = carry ? prod[PROD_W-2 -: MANT_W] : prod[PROD_W-3 -: MANT_W];
`ifdef FP_MUL_ROUND_EN
        guard    = carry ? prod[MANT_W] : prod[MANT_W-1];
        sticky   = carry ? (|prod[MANT_W-1:0]) : (|prod[MANT_W-2:0]);
        round_up = guard & (sticky | frac[0]);
        sig_r    = {2'b01, frac} + (MANT_W+2)'(round_up);
        if (sig_r[MANT_W+1]) begin
            rcarry = 1'b1;
            frac   = sig_r[MANT_W:1];
        end else begin
            frac   = sig_r[MANT_W-1:0];
        end
`endif
        exp_s = $signed(EXP_W'(exp_a) + EXP_W'(exp_b) - EXP_W'(BIAS)
                        + EXP_W'(carry) + EXP_W'(rcarry));

        if (zero_op) begin
            result_c = fp_pack(sign, '0, '0);
        end else if (exp_s >= EXP_MAX_S) begin
            result_c   = fp_pack(sign, EXP_FW'(EXP_MAX), '0);
            overflow_c = 1'b1;
        end else if (exp_s <= $signed(EXP_W'(0))) begin
            result_c    = fp_pack(sign, '0, '0);
            underflow_c = 1'b1;
        end else begin
            result_c = fp_pack(sign, exp_s[EXP_FW-1:0], frac);
        end
    end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 single-precision multiplier: one shift-add step per
// enabled cycle, 25 enabled cycles from capture to done.
// Optional feature macro: FP_MUL_ROUND_EN (round-to-nearest-even in NORM).
module fp_mul_iter
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        busy,
    output logic        done
);

    state_t              state;
    state_t              state_nxt;
    logic                capture;
    logic                step;
    logic                finish;

    fp32_t               a_f;
    fp32_t               b_f;
    logic                sign_r;
    logic [EXP_FW-1:0]   ea_r;
    logic [EXP_FW-1:0]   eb_r;
    logic [SIG_W-1:0]    ma_r;
    logic [SIG_W-1:0]    mb_r;
    logic [PROD_W-1:0]   acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [SIG_W:0]      sum_c;

    fp32_t               norm_res_c;
    logic                norm_ovf_c;
    logic                norm_unf_c;

    assign a_f = A;
    assign b_f = B;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and step controls; nothing advances while en is low.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (en && load) begin
                    capture   = 1'b1;
                    state_nxt = MULT;
                end
            end
            MULT: begin
                if (en) begin
                    step = 1'b1;
                    if (cnt_r == CNT_W'(SIG_W - 1)) begin
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (en) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Upper accumulator half plus the multiplicand when the multiplier LSB is set.
    always_comb begin
        sum_c = {1'b0, acc_r[PROD_W-1:SIG_W]} + (mb_r[0] ? {1'b0, ma_r} : '0);
    end

    // Operand capture and shift-add datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            ea_r   <= '0;
            eb_r   <= '0;
            ma_r   <= '0;
            mb_r   <= '0;
            acc_r  <= '0;
            cnt_r  <= '0;
        end else if (capture) begin
            sign_r <= a_f.sign ^ b_f.sign;
            ea_r   <= a_f.exp;
            eb_r   <= b_f.exp;
            ma_r   <= {1'b1, a_f.mant};
            mb_r   <= {1'b1, b_f.mant};
            acc_r  <= '0;
            cnt_r  <= '0;
        end else if (step) begin
            acc_r  <= {sum_c, acc_r[SIG_W-1:1]};
            mb_r   <= {1'b0, mb_r[SIG_W-1:1]};
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    fp_normalize u_norm (
        .sign        (sign_r),
        .exp_a       (ea_r),
        .exp_b       (eb_r),
        .prod        (acc_r),
        .result_c    (norm_res_c),
        .overflow_c  (norm_ovf_c),
        .underflow_c (norm_unf_c)
    );

    // Registered outputs: busy spans capture..done, result/flags load with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (capture) begin
                busy <= 1'b1;
            end
            if (finish) begin
                busy      <= 1'b0;
                result    <= norm_res_c;
                overflow  <= norm_ovf_c;
                underflow <= norm_unf_c;
            end
        end
    end

endmodule

// File: doc/fp_mul_iter.md
FP_MUL_ITER -- requirements
Module: fp_mul_iter

Interface
REQ-001 SHALL have no parameters; all widths fixed by IEEE-754 single precision.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: en  input  1  clock enable; low freezes all state and outputs.
REQ-005 SHALL have port: load  input  1  start request; operands captured when en=1, load=1 and not busy.
REQ-006 SHALL have port: A  input  32  multiplicand, IEEE-754 single.
REQ-007 SHALL have port: B  input  32  multiplier, IEEE-754 single.
REQ-008 SHALL have port: result  output  32  registered product, held until next done.
REQ-009 SHALL have port: overflow  output  1  exponent overflow flag, valid with done.
REQ-010 SHALL have port: underflow  output  1  exponent underflow flag, valid with done.
REQ-011 SHALL have port: busy  output  1  high from capture edge until done edge.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when result is updated.

Function
REQ-013 SHALL use FSM states IDLE, MULT, NORM; IDLE->MULT on capture, MULT->NORM after 24 iterations, NORM->IDLE after one cycle.
REQ-014 SHALL, on capture, latch signs, exponents and 24-bit mantissas (hidden 1 restored), and clear the 48-bit accumulator and 5-bit counter.
REQ-015 SHALL, in MULT, perform one shift-add step per enabled cycle: add the multiplicand to the accumulator if the current multiplier LSB is 1, then shift.
REQ-016 SHALL, in NORM, select product bits [46:23] if bit 47 is clear, else [47:24] with exponent +1; exponent = EA + EB - 127 + carry, computed 10-bit signed.
REQ-017 SHALL assert done and update result/flags 25 enabled cycles after the capture edge; busy SHALL fall on the same edge.
REQ-018 SHALL set sign = A[31] XOR B[31] for all results, including zero and infinity.
REQ-019 SHALL treat any operand with exponent field 0 as zero; the result SHALL be a signed zero with both flags clear.
REQ-020 SHALL, on biased exponent >= 255, output signed infinity (exp 255, mantissa 0) with overflow=1.
REQ-021 SHALL, on biased exponent <= 0 (non-zero operands), output signed zero with underflow=1.
REQ-022 SHALL ignore load while busy; operands SHALL NOT be re-captured.
REQ-023 SHALL, with en=0 in any state, hold the counter, accumulator and FSM state, and SHALL NOT assert done.
REQ-024 SHALL NOT handle NaN or infinity inputs specially; exp-255 inputs follow the normal overflow path.

Reset
REQ-025 SHALL, on rst high at any time, immediately clear result, overflow, underflow, busy and done to 0 and set the FSM to IDLE.
REQ-026 SHALL, when rst is asserted mid-operation, abandon that operation; no done SHALL follow it.

Configuration
REQ-027 SHALL, with FP_MUL_ROUND_EN defined, round to nearest-even using guard and sticky bits in NORM; mantissa carry-out SHALL increment the exponent before the overflow check.
REQ-028 SHALL, without FP_MUL_ROUND_EN, truncate; latency SHALL be identical in both builds.

Structure
REQ-029 SHALL place the fp32 field typedef and the constants BIAS=127, EXP_MAX=255, MANT_W=23 in shared package fp_pkg.
REQ-030 SHALL implement NORM arithmetic (normalise, round, flag, pack) in combinational sub-module fp_normalize.

Verification
REQ-031 SHALL cover basic latency: A=0x40000000, B=0x40400000 -> result=0x40C00000, done 25 cycles after load, flags 0.
REQ-032 SHALL cover normalisation carry: A=B=0x3FC00000 -> result=0x40100000.
REQ-033 SHALL cover signed zero: A=0x00000000, B=0xC0A00000 -> result=0x80000000, flags 0.
REQ-034 SHALL cover overflow and underflow:
- A=B=0x7F000000 -> result=0x7F800000, overflow=1.
- A=B=0x00800000 -> result=0x00000000, underflow=1.
REQ-035 SHALL cover rounding: A=0x3F800001, B=0x3FC00000 -> result=0x3FC00001 without FP_MUL_ROUND_EN, 0x3FC00002 with it.
REQ-036 SHALL cover reset and load-while-busy:
- rst pulse 10 cycles after load -> all outputs 0, no done.
- load during busy -> ignored, original product delivered.
